// File: rtl/gpr_write_arbiter.sv
// gpr_write_arbiter
//
// Shares the single write port of the general-purpose register file between
// requester A (ALU result) and requester B (memory load result). Requests are
// accepted over valid/ready handshakes. Contention is resolved by fixed
// priority (A over B) or, when the GPR_ARB_RR_EN macro is defined, by
// round-robin. The write port is driven from a registered output stage, so an
// accepted request appears on the register file inputs one cycle later.
//
// Build option:
//   GPR_ARB_RR_EN  defined   -> round-robin arbitration on contended cycles
//                  undefined -> fixed priority, A always wins
//
// Parameters:
//   DATA_W   width of the write data
//   ADDR_W   width of the register index
//   STALL_W  width of the saturating contention counter
//
// Ports:
//   clock           system clock, all state on the rising edge
//   reset           asynchronous, active-high
//   a_valid/a_reg/a_data/a_ready   requester A handshake and payload
//   b_valid/b_reg/b_data/b_ready   requester B handshake and payload
//   o_write_reg     register-file write index
//   o_write_data    register-file write data
//   o_write_enable  register-file write strobe (never asserted for r0)
//   o_stall_count   saturating count of cycles with both requesters valid
//   o_last_grant    winner of the most recent contended cycle (0 = A, 1 = B)

module gpr_write_arbiter #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 8
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_reg,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,

    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_reg,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,

    output logic [ADDR_W-1:0]   o_write_reg,
    output logic [DATA_W-1:0]   o_write_data,
    output logic                o_write_enable,
    output logic [STALL_W-1:0]  o_stall_count,
    output logic                o_last_grant
);

    logic last_grant;
    logic prefer_a;
    logic prefer_b;
    logic a_fire;
    logic b_fire;
    logic contended;

    // In round-robin mode the requester that did not win the previous
    // contended cycle is preferred. last_grant resets to 1 (B), so A wins
    // the first contention after reset.
`ifdef GPR_ARB_RR_EN
    assign prefer_a = last_grant;
`else
    assign prefer_a = 1'b1;
`endif
    assign prefer_b = !prefer_a;

    // Each ready depends only on the other requester's valid and on the
    // preference, never on its own valid. Readies are forced low while reset
    // is held so nothing is consumed during reset.
    assign a_ready = !reset && !(b_valid && prefer_b);
    assign b_ready = !reset && !(a_valid && prefer_a);

    assign a_fire    = a_valid && a_ready;
    assign b_fire    = b_valid && b_ready;
    assign contended = a_valid && b_valid;

    // Output stage, contention counter and last-grant flop. A transfer to
    // register 0 is consumed but leaves the write strobe low, so r0 is never
    // written through this block. Without a transfer the strobe drops and
    // the index/data hold their previous values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_write_reg    <= '0;
            o_write_data   <= '0;
            o_write_enable <= 1'b0;
            o_stall_count  <= '0;
            last_grant     <= 1'b1;
        end else begin
            if (a_fire) begin
                o_write_reg    <= a_reg;
                o_write_data   <= a_data;
                o_write_enable <= (a_reg != '0);
            end else if (b_fire) begin
                o_write_reg    <= b_reg;
                o_write_data   <= b_data;
                o_write_enable <= (b_reg != '0);
            end else begin
                o_write_enable <= 1'b0;
            end

            // Only contended cycles move the grant history; the counter
            // stops at its maximum instead of wrapping.
            if (contended) begin
                last_grant <= prefer_b;
                if (o_stall_count != {STALL_W{1'b1}}) begin
                    o_stall_count <= o_stall_count + {{(STALL_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign o_last_grant = last_grant;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// tb_gpr_write_arbiter
//
// Self-checking bench for gpr_write_arbiter with default parameters. A
// behavioural model tracks who wins each contention, the expected write-port
// contents and the saturating contention count; directed scenarios are
// followed by randomized requesters that hold their payload until accepted.

module tb_gpr_write_arbiter;

    logic         clock;
    logic         reset;
    logic         a_valid;
    logic [4:0]   a_reg;
    logic [31:0]  a_data;
    logic         a_ready;
    logic         b_valid;
    logic [4:0]   b_reg;
    logic [31:0]  b_data;
    logic         b_ready;
    logic [4:0]   o_write_reg;
    logic [31:0]  o_write_data;
    logic         o_write_enable;
    logic [7:0]   o_stall_count;
    logic         o_last_grant;

    int total;
    int bad;

    // Behavioural model state
    logic         m_last;
    int           m_stall;
    logic         m_we;
    logic [4:0]   m_reg;
    logic [31:0]  m_data;

    gpr_write_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_reg          (a_reg),
        .a_data         (a_data),
        .a_ready        (a_ready),
        .b_valid        (b_valid),
        .b_reg          (b_reg),
        .b_data         (b_data),
        .b_ready        (b_ready),
        .o_write_reg    (o_write_reg),
        .o_write_data   (o_write_data),
        .o_write_enable (o_write_enable),
        .o_stall_count  (o_stall_count),
        .o_last_grant   (o_last_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_last  = 1'b1;
        m_stall = 0;
        m_we    = 1'b0;
        m_reg   = '0;
        m_data  = '0;
    endtask

    task automatic checkWritePort();
        checkOutput("write_enable", 32'(o_write_enable), 32'(m_we));
        checkOutput("write_reg", 32'(o_write_reg), 32'(m_reg));
        checkOutput("write_data", o_write_data, m_data);
        checkOutput("stall_count", 32'(o_stall_count), 32'(m_stall));
        checkOutput("last_grant", 32'(o_last_grant), 32'(m_last));
    endtask

    // Drives one cycle of requests, checks readies against the model just
    // after driving, then checks the write port after the rising edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                 output logic a_acc, output logic b_acc);
        logic b_would_win;
        logic exp_ar;
        logic exp_br;
        @(negedge clock);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #1;
`ifdef GPR_ARB_RR_EN
        // B wins a contention only if A won the previous one
        b_would_win = (m_last == 1'b0);
`else
        b_would_win = 1'b0;
`endif
        exp_ar = !(bv && b_would_win);
        exp_br = !(av && !b_would_win);
        checkOutput("a_ready", 32'(a_ready), 32'(exp_ar));
        checkOutput("b_ready", 32'(b_ready), 32'(exp_br));
        a_acc = av && exp_ar;
        b_acc = bv && exp_br;
        @(posedge clock);
        #1;
        if (a_acc) begin
            m_reg = ar; m_data = ad; m_we = (ar != 5'd0);
        end else if (b_acc) begin
            m_reg = br; m_data = bd; m_we = (br != 5'd0);
        end else begin
            m_we = 1'b0;
        end
        if (av && bv) begin
            m_last = b_would_win;
            if (m_stall < 255) m_stall++;
        end
        checkWritePort();
    endtask

    task automatic idleCycle();
        logic x, y;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x, y);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        modelReset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Both requesters present a payload and hold it until accepted.
    task automatic runPair(input logic [4:0] ar, input logic [31:0] ad,
                           input logic [4:0] br, input logic [31:0] bd);
        logic pa, pb, aa, ba;
        int c;
        pa = 1'b1;
        pb = 1'b1;
        c = 0;
        while ((pa || pb) && c < 10) begin
            applyStimulus(pa, ar, ad, pb, br, bd, aa, ba);
            if (aa) pa = 1'b0;
            if (ba) pb = 1'b0;
            c++;
        end
        checkOutput("pair_timeout", 32'(pa || pb), 32'd0);
    endtask

    initial begin
        logic aa, ba;
        logic pa, pb;
        logic [4:0]  par, pbr;
        logic [31:0] pad, pbd;

        total = 0;
        bad = 0;
        reset = 1'b1;
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h5;
        b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h6;
        modelReset();
        #3;
        // Reset state, readies held low even with requests present
        checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
        checkOutput("reset_b_ready", 32'(b_ready), 32'd0);
        checkWritePort();
        @(negedge clock);
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset = 1'b0;

        // Single A write with one-cycle latency, strobe drops afterwards
        applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'd0, aa, ba);
        checkOutput("single_we", 32'(o_write_enable), 32'd1);
        checkOutput("single_reg", 32'(o_write_reg), 32'd3);
        checkOutput("single_data", o_write_data, 32'h12345678);
        idleCycle();
        checkOutput("single_we_drop", 32'(o_write_enable), 32'd0);

        // Contended pair: A first after reset in either build
        runPair(5'd4, 32'hAAAA0000, 5'd5, 32'hBBBB0000);
        checkOutput("pair_stall", 32'(o_stall_count), 32'd1);
        runPair(5'd4, 32'hAAAA0001, 5'd5, 32'hBBBB0001);
        idleCycle();

        // Write to r0 is consumed without a strobe
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, aa, ba);
        checkOutput("r0_accepted", 32'(ba), 32'd1);
        checkOutput("r0_no_we", 32'(o_write_enable), 32'd0);

        // Same destination register from both sides, right after reset
        doReset();
        runPair(5'd7, 32'h1, 5'd7, 32'h2);
        checkOutput("same_reg_final", o_write_data, 32'h2);
        idleCycle();

        // Long contention: counter saturates, grant pattern checked per cycle
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i), 1'b1, 5'(i + 1), 32'(i) ^ 32'hFFFF0000, aa, ba);
        end
        checkOutput("stall_saturated", 32'(o_stall_count), 32'd255);
        idleCycle();

        // Reset mid-operation clears the output stage without a clock edge
        doReset();
        applyStimulus(1'b1, 5'd11, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, aa, ba);
        checkOutput("pre_reset_we", 32'(o_write_enable), 32'd1);
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput("async_a_ready", 32'(a_ready), 32'd0);
        checkWritePort();
        @(negedge clock);
        a_valid = 1'b0;
        reset = 1'b0;

        // Randomized requesters holding payloads until accepted
        pa = 1'b0; pb = 1'b0;
        par = '0; pbr = '0; pad = '0; pbd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pa && ($urandom_range(0, 9) < 6)) begin
                pa = 1'b1;
                par = 5'($urandom_range(0, 31));
                pad = $urandom;
            end
            if (!pb && ($urandom_range(0, 9) < 6)) begin
                pb = 1'b1;
                pbr = 5'($urandom_range(0, 31));
                pbd = $urandom;
            end
            applyStimulus(pa, par, pad, pb, pbr, pbd, aa, ba);
            if (aa) pa = 1'b0;
            if (ba) pb = 1'b0;
        end
        idleCycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_write_arbiter.md
# gpr_write_arbiter

Arbiter that shares the single write port of the general-purpose register file between two writeback requesters: requester A (ALU result) and requester B (memory load result). It accepts requests over valid/ready handshakes and resolves contention by fixed priority, or by round-robin when configured. It drives the register file's write-register, write-data and write-enable inputs through a registered output stage. It sits between the execute/memory stages and the register file, and reports contention statistics for debug.

## Interface
- DATA_W, 32, width of the write data
- ADDR_W, 5, width of the register index
- STALL_W, 8, width of the contention counter
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- a_valid  in  1  requester A has a write pending
- a_reg  in  ADDR_W  requester A destination register
- a_data  in  DATA_W  requester A write data
- a_ready  out  1  requester A accepted this cycle when a_valid is also high
- b_valid, b_reg, b_data, b_ready  same as A, for requester B
- o_write_reg  out  ADDR_W  register-file write index
- o_write_data  out  DATA_W  register-file write data
- o_write_enable  out  1  register-file write strobe
- o_stall_count  out  STALL_W  saturating count of contention cycles
- o_last_grant  out  1  0 = A, 1 = B; the winner of the most recent contended cycle

## Operation
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Requesters hold reg/data stable while valid is high and not yet accepted.
- Ready generation (combinational from valid inputs and arbitration state):
  - a_ready = !(b_valid && prefer_b)
  - b_ready = !(a_valid && prefer_a)
  - Each ready is independent of its own valid.
  - Exactly one requester wins when both are valid.
- Priority without the macro: prefer_a is always 1, so A wins every contention.
- Priority with the macro: the winner is the requester that did not win the previous contended cycle. The last-grant flop updates only on contended cycles.
- Output stage, on each accepted transfer:
  - o_write_reg and o_write_data load the winner's reg/data.
  - o_write_enable = 1, unless the winner's reg == 0.
  - A write to register 0 is accepted (ready high, request consumed) but produces o_write_enable = 0, so r0 is never written through this block.
- With no transfer, o_write_enable = 0 next cycle. o_write_reg and o_write_data hold their previous values.
- Contention counter:
  - o_stall_count increments by 1 on every cycle with a_valid && b_valid.
  - It saturates at 2^STALL_W-1 and never wraps.
- Same destination register from both requesters in one cycle: the loser is written one or more cycles after the winner. The final register value is the loser's data. No merging, no dropping.

## Timing
- Reset values:
  - o_write_enable = 0, o_write_reg = 0, o_write_data = 0
  - o_stall_count = 0
  - o_last_grant = 1, so A wins the first contention under round-robin
  - a_ready = b_ready = 0 while reset is high
- Latency: one cycle, from acceptance edge to o_write_enable high. The register file commits at the following edge.
- Throughput: one write per cycle. Back-to-back acceptances produce consecutive o_write_enable pulses.
- A single valid requester is accepted in the same cycle (zero wait).
- Under contention the loser waits at least one cycle. Under round-robin, with both continuously valid, grants alternate A, B, A, B.
- Reset asserted mid-operation clears the output stage immediately (asynchronous). A pending write in the output register is lost. Requesters see ready low and must re-present after reset.
- An accepted request whose valid stays high next cycle is treated as a new request.

## Configuration
- GPR_ARB_RR_EN defined: round-robin arbitration using the last-grant flop; o_last_grant tracks the contended winner.
- GPR_ARB_RR_EN undefined:
  - Fixed priority, A over B.
  - The last-grant flop is still updated on contention, so o_last_grant reads 0 after any contention.
  - B may starve while A is continuously valid.

## Test plan
- Reset, then a_valid=1, a_reg=3, a_data=0x12345678 for one cycle -> a_ready=1; next cycle o_write_enable=1, o_write_reg=3, o_write_data=0x12345678; the cycle after, o_write_enable=0.
- Both valid, a_reg=4/0xAAAA0000 and b_reg=5/0xBBBB0000, held until accepted:
  - Without the macro -> A written first, B next cycle; o_stall_count=1.
  - With the macro -> same first order, then alternation on repeated contention.
- Both valid continuously for 300 cycles, STALL_W=8:
  - o_stall_count saturates at 255.
  - Round-robin build -> grant sequence A,B,A,B...
  - Fixed build -> B never ready.
- b_valid=1, b_reg=0, b_data=0xFFFFFFFF -> b_ready=1; next cycle o_write_enable=0.
- Both requesters target reg 7, A=0x1, B=0x2, fixed priority -> writes to reg 7 appear in order 0x1 then 0x2.
- Assert reset on the cycle after an acceptance -> o_write_enable drops to 0 without waiting for an edge, and all outputs return to their reset values.
